// File: rtl/otter_uart_pkg.sv
// Shared UART definitions: transmitter FSM state encoding and default build constants.
package otter_uart_pkg;

    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned UART_DEFAULT_FIFO_DEPTH   = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; full/empty derive from a registered count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             RD,
    output logic [WIDTH-1:0] RDATA,
    output logic             FULL,
    output logic             EMPTY
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    // A write while full is dropped even if a read frees a slot on the same edge.
    assign push  = WR && !FULL;
    assign pop   = RD && !EMPTY;
    assign FULL  = (count == (AW + 1)'(DEPTH));
    assign EMPTY = (count == '0);
    assign RDATA = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= WDATA;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: MMIO writes queue bytes, the FSM drains them back to back.
module uart_tx_fifo
    import otter_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = UART_DEFAULT_FIFO_DEPTH
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [7:0] DATA,
    output logic       READY,
    output logic       TX,
    output logic       BUSY
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_tx_state_t state, state_next;
    logic [BW-1:0]  baud_cnt, baud_next;
    logic [2:0]     bit_idx, bit_idx_next;
    logic [7:0]     shift_reg, shift_next;
    logic           tx_reg;
    logic           baud_end;
    logic           fifo_rd;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_rdata;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .WR    (START),
        .WDATA (DATA),
        .RD    (fifo_rd),
        .RDATA (fifo_rdata),
        .FULL  (fifo_full),
        .EMPTY (fifo_empty)
    );

    assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign READY    = !fifo_full;
    assign BUSY     = !fifo_empty || (state != IDLE);
    assign TX       = tx_reg;

    always_comb begin
        state_next   = state;
        baud_next    = baud_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        fifo_rd      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd    = 1'b1;
                    shift_next = fifo_rdata;
                    baud_next  = '0;
                    state_next = START_BIT;
                end
            end
            START_BIT: begin
                if (baud_end) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA_BITS;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA_BITS: begin
                if (baud_end) begin
                    baud_next    = '0;
                    bit_idx_next = bit_idx + 1'b1;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP_BIT;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP_BIT: begin
                if (baud_end) begin
                    baud_next = '0;
                    // Chain straight into the next start bit so queued frames have no idle gap.
                    if (!fifo_empty) begin
                        fifo_rd    = 1'b1;
                        shift_next = fifo_rdata;
                        state_next = START_BIT;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
        end
    end

    // Line level is registered from the current state, so TX trails the FSM by one cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_reg <= 1'b1;
        end else begin
            case (state)
                START_BIT: tx_reg <= 1'b0;
                DATA_BITS: tx_reg <= shift_reg[0];
                default:   tx_reg <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues expected bytes, a serial monitor decodes TX and compares.
module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic [7:0] DATA  = 8'h00;
    logic       READY;
    logic       TX;
    logic       BUSY;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned frames      = 0;
    bit          mon_active  = 1'b0;
    logic [7:0]  exp_q[$];
    int unsigned starts[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .DATA  (DATA),
        .READY (READY),
        .TX    (TX),
        .BUSY  (BUSY)
    );

    initial forever #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned n = 0;
        @(negedge CLK);
        #1;
        while ((BUSY || mon_active) && n < budget) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("idle_reached", {30'd0, BUSY, mon_active}, 32'd0);
        repeat (3) @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Serial monitor: samples TX every cycle and decodes 40-cycle frames.
    initial begin
        logic [39:0] smp;
        int          n;
        bit          stable;
        logic [7:0]  got;
        n = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                mon_active = 1'b0;
                n = 0;
            end else if (!mon_active) begin
                if (TX === 1'b0) begin
                    mon_active = 1'b1;
                    smp = '0;
                    smp[0] = TX;
                    n = 1;
                    starts.push_back(cyc);
                end
            end else begin
                smp[n] = TX;
                n++;
                if (n == 40) begin
                    stable = 1'b1;
                    for (int b = 0; b < 10; b++) begin
                        for (int k = 1; k < 4; k++) begin
                            if (smp[4*b+k] !== smp[4*b]) stable = 1'b0;
                        end
                    end
                    for (int i = 0; i < 8; i++) got[i] = smp[4*(i+1)];
                    frames++;
                    check("bit_hold", {31'd0, stable}, 32'd1);
                    check("stop_bit", {31'd0, smp[36]}, 32'd1);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame: got %0h required none", got);
                    end else begin
                        check("frame_data", got, exp_q.pop_front());
                    end
                    mon_active = 1'b0;
                    n = 0;
                end
            end
        end
    end

    initial begin
        logic [9:0]  pat;
        int unsigned c0;
        int unsigned frames_before;

        repeat (3) @(negedge CLK);
        #1;
        check("rst_tx", TX, 1);
        check("rst_ready", READY, 1);
        check("rst_busy", BUSY, 0);
        RST_N = 1'b1;

        // DATA wiggles with START low: nothing may be queued.
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            DATA = 8'h5A ^ 8'(i * 37);
            #1;
            check("ignore_tx", TX, 1);
            check("ignore_busy", BUSY, 0);
        end

        // Single byte 0xA5 with latency and bit timing.
        @(negedge CLK);
        START = 1'b1;
        DATA  = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge CLK);
        START = 1'b0;
        DATA  = 8'h00;
        #1;
        check("lat_e0_tx", TX, 1);
        check("lat_e0_busy", BUSY, 1);
        @(negedge CLK);
        #1;
        check("lat_e1_tx", TX, 1);
        pat = 10'b11_0100_1010;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            #1;
            check("a5_tx_seq", TX, pat[k/4]);
            if (k == 38) check("a5_busy_last", BUSY, 1);
            if (k == 39) check("a5_busy_drop", BUSY, 0);
        end
        wait_idle(50);

        // Back-to-back 0x00, 0xFF.
        starts.delete();
        @(negedge CLK);
        START = 1'b1;
        DATA  = 8'h00;
        exp_q.push_back(8'h00);
        @(negedge CLK);
        c0   = cyc;
        DATA = 8'hFF;
        exp_q.push_back(8'hFF);
        @(negedge CLK);
        START = 1'b0;
        wait_idle(200);
        check("b2b_frames", starts.size(), 2);
        if (starts.size() == 2) begin
            check("b2b_first_start", starts[0] - c0, 2);
            check("b2b_gap", starts[1] - starts[0], 40);
        end

        // Fill while transmitting: 0x10 then 0x01..0x05, the fifth is dropped.
        @(negedge CLK);
        START = 1'b1;
        DATA  = 8'h10;
        exp_q.push_back(8'h10);
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            #1;
            check("full_ready", READY, (i <= 4) ? 1 : 0);
            DATA = 8'(i);
            if (i <= 4) exp_q.push_back(8'(i));
        end
        @(negedge CLK);
        #1;
        check("full_ready_after5", READY, 0);
        START = 1'b0;
        wait_idle(400);

        // Push coinciding with the stop-bit pop while full.
        @(negedge CLK);
        START = 1'b1;
        DATA  = 8'h20;
        exp_q.push_back(8'h20);
        @(negedge CLK);
        c0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            DATA = 8'h20 + 8'(i);
            exp_q.push_back(8'h20 + 8'(i));
            @(negedge CLK);
        end
        START = 1'b0;
        #1;
        check("pop_full_ready", READY, 0);
        while (cyc < c0 + 40) @(negedge CLK);
        #1;
        check("pop_ready_before", READY, 0);
        START = 1'b1;
        DATA  = 8'h99;
        @(negedge CLK);
        START = 1'b0;
        #1;
        check("pop_ready_after", READY, 1);
        check("pop_count", dut.u_fifo.count, 3);
        wait_idle(300);

        // Reset at cycle 15 of frame 0x3C with two bytes still queued.
        @(negedge CLK);
        START = 1'b1;
        DATA  = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge CLK);
        c0   = cyc;
        DATA = 8'h3D;
        @(negedge CLK);
        DATA = 8'h3E;
        @(negedge CLK);
        START = 1'b0;
        while (cyc < c0 + 2 + 15) @(negedge CLK);
        #1;
        check("pre_rst_busy", BUSY, 1);
        check("pre_rst_full_q", dut.u_fifo.count, 2);
        #1;
        RST_N = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_tx", TX, 1);
        check("midrst_ready", READY, 1);
        check("midrst_busy", BUSY, 0);
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RST_N = 1'b1;
        frames_before = frames;
        repeat (80) @(negedge CLK);
        #1;
        check("post_rst_frames", frames - frames_before, 0);
        check("post_rst_tx", TX, 1);
        check("post_rst_busy", BUSY, 0);
        check("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
